// File: rtl/serial_subtractor_16bit_pkg.sv
// Shared constants and state encoding for the bit-serial subtractor.
package serial_subtractor_16bit_pkg;

  localparam int DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  // Bit-counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: x - y - bin, producing difference and borrow.
module full_subtractor (
  input  logic i_x,
  input  logic i_y,
  input  logic i_bin,
  output logic o_d,
  output logic o_bo
);

  assign o_d  = i_x ^ i_y ^ i_bin;
  assign o_bo = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);

endmodule

// File: rtl/serial_subtractor_16bit.sv
// Bit-serial a - b: one full-subtractor cell walks the operands LSB first,
// producing diff, unsigned borrow-out and signed overflow after WIDTH cycles.
module serial_subtractor_16bit
  import serial_subtractor_16bit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_diff_sh;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_count;
  logic             r_borrow;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_bout;
  logic             r_ovf;
  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic [WIDTH-1:0] w_diff_next;

  full_subtractor u_fs (
    .i_x  (r_a_sh[0]),
    .i_y  (r_b_sh[0]),
    .i_bin(r_borrow),
    .o_d  (w_d),
    .o_bo (w_bo)
  );

  assign w_last      = (r_count == CW'(WIDTH - 1));
  assign w_diff_next = {w_d, r_diff_sh[WIDTH-1:1]};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_RUN;
      S_RUN:   if (w_last)   w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_diff_sh <= '0;
      r_diff    <= '0;
      r_count   <= '0;
      r_borrow  <= 1'b0;
      r_a_msb   <= 1'b0;
      r_b_msb   <= 1'b0;
      r_bout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_borrow <= 1'b0;
            r_count  <= '0;
          end
        end
        S_RUN: begin
          r_a_sh    <= r_a_sh >> 1;
          r_b_sh    <= r_b_sh >> 1;
          r_diff_sh <= w_diff_next;
          r_borrow  <= w_bo;
          r_count   <= r_count + CW'(1);
          if (w_last) begin
            r_diff <= w_diff_next;
            r_bout <= w_bo;
            // Overflow only when signs differ and the result sign leaves the minuend's.
            r_ovf  <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule

// File: doc/serial_subtractor_16bit.md
Name: serial_subtractor_16bit

Overview:
- Bit-serial 16-bit subtractor computing diff = a − b with a ripple borrow, one bit per clock.
- Inverse companion to the 16-bit ripple-carry adder in the arithmetic library.
- Trades latency for area: one full-subtractor cell plus shift registers.
- Valid/ready handshakes on input and output; raises unsigned borrow-out and signed overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits (counter sized $clog2(WIDTH)).

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b present
- in_ready  output  1  block idle and able to accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result available; held until accepted
- out_ready  input  1  downstream accepts result
- diff  output  WIDTH  a − b modulo 2^WIDTH
- bout  output  1  borrow out (1 when a < b, unsigned)
- ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low on rst_n, so assertion clears state immediately, independent of clk.
- Reset values: state=IDLE, diff=0, bout=0, ovf=0, out_valid=0, counter=0, internal borrow=0, shift registers=0.
- in_ready = (state==IDLE), decoded from the state register. It reads 1 while rst_n is low and is sampled only after release.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on in_valid && in_ready:
  - capture a and b into shift registers a_sh and b_sh
  - latch a[WIDTH-1] and b[WIDTH-1]
  - borrow=0, count=0
- RUN, each cycle:
  - full_subtractor(a_sh[0], b_sh[0], borrow) produces d and bo
  - d is shifted into the MSB of diff_sh, diff_sh shifts right
  - a_sh and b_sh shift right
  - borrow ← bo, count++
- RUN → DONE on the cycle with count==WIDTH-1. That edge also loads:
  - diff ← completed diff_sh
  - bout ← final bo
  - ovf ← (a_msb != b_msb) && (final d != a_msb)
- DONE: out_valid=1. diff, bout and ovf are stable.
- DONE → IDLE on out_ready. out_valid drops on that same edge.
- Latency: the accept edge is E0. Bits are processed on E1..E_WIDTH. out_valid is high from E_WIDTH, i.e. 16 cycles after accept.
- Throughput: at most one operation per WIDTH+2 cycles.
- Backpressure:
  - in_ready=0 during RUN and DONE; in_valid is ignored there.
  - With out_ready low, DONE holds indefinitely with outputs frozen.
- Simultaneous events: out_ready in DONE together with in_valid high only returns to IDLE. The new accept occurs on the following edge; there is no same-cycle accept.
- diff, bout and ovf keep the last result after the handshake, until the next completion or reset. Their values are meaningful only while out_valid=1.
- Reset mid-operation (RUN or DONE): the operation is discarded and all registers return to reset values. No out_valid pulse follows release.
- Arithmetic:
  - modulo 2^WIDTH
  - bout = unsigned a < b
  - ovf uses the sign bits of the original operands, not the shifted copies
- No X propagation on any output after reset.

Decomposition:
- Shared arithmetic package holds:
  - WIDTH default constant
  - state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2)
  - counter width derived from WIDTH
- Sub-module full_subtractor (combinational):
  - d = x ^ y ^ bin
  - bo = (~x & y) | (~(x ^ y) & bin)
- Counterpart to the library's full_adder cell. Instantiated once.

Test Plan:
- a=0x1234, b=0x0034 accepted at E0 → out_valid at E16; diff=0x1200, bout=0, ovf=0.
- a=0x0000, b=0x0001 → diff=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001 → diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF → diff=0x8000, bout=1, ovf=1.
- Backpressure:
  - a=0xFFFF, b=0xFFFF, out_ready held low 5 cycles after out_valid → diff=0x0000, bout=0, ovf=0 held stable; in_ready=0.
  - A competing in_valid with a=0x0001 is not captured.
  - Result is accepted when out_ready rises.
- Reset mid-RUN: rst_n low at bit 7 → outputs 0 immediately and in_ready=1. After release, no out_valid appears without a new in_valid.
- Back-to-back with in_valid and out_ready held high, operands 0x0010−0x0001 then 0x0001−0x0010:
  - results 0x000F (bout=0), then 0xFFF1 (bout=1)
  - accept edges 18 cycles apart
